// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared FSM encoding and address-window helpers for the APB bridge
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h4000_0000;
  localparam int          DEF_WINDOW_LOG2 = 12;

  // Offset bits inside the window; the complement selects the tag bits.
  function automatic logic [63:0] win_mask(input int window_log2);
    return (64'd1 << window_log2) - 64'd1;
  endfunction

  function automatic logic [63:0] win_tag(input logic [63:0] base, input int window_log2);
    return base & ~win_mask(window_log2);
  endfunction

endpackage

// File: rtl/apb_bridge_timeout_if.sv
// rtl/apb_bridge_timeout_if.sv - APB bus bundle with requester (master) and completer (slave) views
interface apb_bridge_timeout_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - downstream wait-state counter flagging the last permitted ACCESS cycle
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_bypass
      assign terminal = 1'b0;
    end else begin : g_count
      localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
      logic [CNT_WIDTH-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end

      assign terminal = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_bridge_timeout.sv
// rtl/apb_bridge_timeout.sv - registered APB-to-APB bridge with window remap and wait-state timeout
module apb_bridge_timeout
  import apb_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter int                    WINDOW_LOG2    = DEF_WINDOW_LOG2,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    CNT_WIDTH      = 9
) (
  input  logic                        pclk,
  input  logic                        preset,
  apb_bridge_timeout_if.slave         up,
  apb_bridge_timeout_if.master        dn,
  output logic                        timeout_evt
);

  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ADDR_WIDTH'(win_mask(WINDOW_LOG2));
  localparam logic [ADDR_WIDTH-1:0] WIN_TAG  = ADDR_WIDTH'(win_tag(64'(BASE_ADDR), WINDOW_LOG2));

  bridge_state_t         state;
  bridge_state_t         state_nx;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  abandon;
  logic                  accept;
  logic                  hit;
  logic                  drop;
  logic                  busy;
  logic                  terminal;
  logic                  tmo;
  logic                  done;

  assign accept = (state == ST_IDLE) && up.psel && up.penable;
  assign hit    = (up.paddr & ~WIN_MASK) == WIN_TAG;
  assign busy   = (state == ST_SETUP) || (state == ST_ACCESS);
  // A requester that let go of PSEL mid-transfer gets no response.
  assign drop   = abandon || !up.psel;
  assign tmo    = (state == ST_ACCESS) && !dn.pready && terminal;
  assign done   = (state == ST_ACCESS) && (dn.pready || tmo);

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_timeout (
    .clk      (pclk),
    .rst      (preset),
    .en       ((state == ST_ACCESS) && !dn.pready),
    .clr      (state != ST_ACCESS),
    .terminal (terminal)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = hit ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (done) state_nx = drop ? ST_IDLE : ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dn.psel    = busy;
    dn.penable = (state == ST_ACCESS);
    dn.paddr   = busy ? (cap_addr & WIN_MASK) : '0;
    dn.pwrite  = busy && cap_write;
    dn.pwdata  = busy ? cap_wdata : '0;
    up.pready  = (state == ST_RESP);
    up.prdata  = (state == ST_RESP) ? rsp_data : '0;
    up.pslverr = (state == ST_RESP) && rsp_err;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cap_addr    <= '0;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      abandon     <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tmo;

      if (accept) begin
        cap_addr  <= up.paddr;
        cap_write <= up.pwrite;
        cap_wdata <= up.pwdata;
        abandon   <= 1'b0;
      end else if (busy && !up.psel) begin
        abandon <= 1'b1;
      end

      // Misses and timeouts answer with an error and no data; writes never return data.
      if (accept && !hit) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (tmo) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (done) begin
        rsp_data <= cap_write ? '0 : dn.prdata;
        rsp_err  <= dn.pslverr;
      end
    end
  end

endmodule

// File: doc/apb_bridge_timeout.md
Name: apb_bridge_timeout

Overview:
- Registered APB-to-APB bridge between the CPU-side APB requester (SLAVE_* port) and a downstream peripheral segment (MASTER_* port).
- Successor to the pass-through bus converter. Adds parametrised address/data width, an address window check with base-offset remapping, a registered downstream SETUP/ACCESS sequence, and a wait-state timeout that returns PSLVERR.
- Sits at the root of each peripheral APB segment so that a hung peripheral cannot stall the core.

Parameters:
- ADDR_WIDTH, 32, upstream and downstream PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- BASE_ADDR, 32'h4000_0000, first upstream address of the window; aligned to 2**WINDOW_LOG2.
- WINDOW_LOG2, 12, window size is 2**WINDOW_LOG2 bytes.
- TIMEOUT_CYCLES, 256, maximum downstream ACCESS cycles; 0 disables the timeout.
- CNT_WIDTH, 9, timeout counter width; must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- PCLK  in  1  bus clock, rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- SLAVE_PADDR  in  ADDR_WIDTH  upstream address.
- SLAVE_PSEL  in  1  upstream select.
- SLAVE_PENABLE  in  1  upstream enable.
- SLAVE_PWRITE  in  1  upstream direction.
- SLAVE_PWDATA  in  DATA_WIDTH  upstream write data.
- SLAVE_PRDATA  out  DATA_WIDTH  upstream read data.
- SLAVE_PREADY  out  1  upstream ready.
- SLAVE_PSLVERR  out  1  upstream error.
- MASTER_PADDR  out  ADDR_WIDTH  remapped downstream address.
- MASTER_PSEL  out  1  downstream select.
- MASTER_PENABLE  out  1  downstream enable.
- MASTER_PWRITE  out  1  downstream direction.
- MASTER_PWDATA  out  DATA_WIDTH  downstream write data.
- MASTER_PRDATA  in  DATA_WIDTH  downstream read data.
- MASTER_PREADY  in  1  downstream ready.
- MASTER_PSLVERR  in  1  downstream error.
- TIMEOUT_EVT  out  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Clock and reset:
  - One clock (PCLK); reset is asynchronous and active-high (PRESET).
  - While PRESET is high, every output is 0, the FSM is in IDLE and the counter is 0.
  - Reset mid-transfer abandons the downstream access immediately, with no response.
- All outputs are registered; no combinational path from the upstream port to the downstream port.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On SLAVE_PSEL & SLAVE_PENABLE, capture PADDR, PWRITE and PWDATA.
  - Window hit means SLAVE_PADDR[ADDR_WIDTH-1:WINDOW_LOG2] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_LOG2].
  - Hit: go to SETUP.
  - Miss: go to RESP with error=1, rdata=0; the downstream port is never touched.
- SETUP: MASTER_PSEL=1, MASTER_PENABLE=0; go to ACCESS next cycle.
- ACCESS:
  - MASTER_PSEL=1, MASTER_PENABLE=1; counter increments each cycle MASTER_PREADY is low.
  - On MASTER_PREADY=1: latch MASTER_PRDATA (reads only; writes latch 0) and MASTER_PSLVERR, then go to RESP.
  - If MASTER_PREADY is low and the counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): abort with error=1, rdata=0, pulse TIMEOUT_EVT, drop MASTER_PSEL/PENABLE, go to RESP.
  - MASTER_PREADY in the same cycle as the final count: the ready wins, with no timeout.
- RESP:
  - SLAVE_PREADY=1 for exactly one cycle with the latched SLAVE_PRDATA/SLAVE_PSLVERR, then IDLE.
  - SLAVE_PRDATA is 0 whenever SLAVE_PREADY=0.
- Downstream address and data:
  - MASTER_PADDR = {zeros, captured_addr[WINDOW_LOG2-1:0]} (offset from BASE_ADDR).
  - MASTER_PADDR, MASTER_PWRITE and MASTER_PWDATA hold stable from SETUP through the end of ACCESS, and are 0 in IDLE/RESP.
- Latency:
  - Upstream access phase seen at cycle T: SETUP at T+1, ACCESS at T+2.
  - Zero-wait downstream: SLAVE_PREADY at T+3.
  - Each downstream wait state adds 1 cycle.
  - Window miss: SLAVE_PREADY at T+1.
- Upstream protocol violation (SLAVE_PSEL drops before RESP):
  - The downstream transfer still completes.
  - The response is discarded (no SLAVE_PREADY) and the FSM returns to IDLE.
- Back-to-back transfers: a new upstream access phase is only accepted in IDLE, so one idle cycle after RESP is permitted and expected.

Decomposition:
- Shared package apb_bridge_pkg: FSM state encoding, and helper constants WIN_MASK and WIN_TAG derived from BASE_ADDR/WINDOW_LOG2.
- One sub-module, apb_timeout_counter: enable, clear, terminal count, TIMEOUT_CYCLES==0 bypass. Everything else stays in the top module.

Test Plan:
- Zero-wait write: addr 0x4000_0010, data 0xDEAD_BEEF -> MASTER_PADDR 0x010, MASTER_PWDATA 0xDEAD_BEEF, SETUP at T+1, SLAVE_PREADY=1 at T+3, SLAVE_PSLVERR=0.
- Read with 3 downstream wait states, MASTER_PRDATA 0x1234_5678 -> SLAVE_PREADY at T+6 with SLAVE_PRDATA 0x1234_5678.
- Window miss, addr 0x5000_0000 -> MASTER_PSEL never rises; SLAVE_PREADY and SLAVE_PSLVERR =1 at T+1, SLAVE_PRDATA 0.
- TIMEOUT_CYCLES=4 with MASTER_PREADY held low -> TIMEOUT_EVT pulse after 4 ACCESS cycles, then SLAVE_PSLVERR=1, SLAVE_PRDATA 0. Repeat with MASTER_PREADY=1 on the 4th cycle -> no error.
- Downstream error: MASTER_PSLVERR=1 with MASTER_PREADY -> SLAVE_PSLVERR=1 in RESP.
- PRESET asserted during ACCESS after 2 wait states -> all outputs 0 asynchronously. After release, a fresh zero-wait read completes normally at T+3.
